// File: rtl/regfile_pkg.sv
// Shared register-file write-back types: widths and the queued write entry.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 2**REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; head is valid the cycle after a push.
// Push is ignored when full and pop is ignored when empty; pointers wrap modulo DEPTH.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                din,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU (latency 1) and queued long-latency (latency >=2) results onto the regfile write port.
// ALU is held off only when the queue head has lost STARVE_LIMIT times; b_ready = queue not full.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [REG_AW-1:0]      a_rd,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   iss_valid,
  input  logic [REG_AW-1:0]      iss_rd,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [REG_AW-1:0]      b_rd,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   we,
  output logic [REG_AW-1:0]      rw,
  output logic [DATA_W-1:0]      rwd,
  output logic [NREG-1:0]        busy,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   waw_err
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  wb_entry_t         head;
  wb_entry_t         push_entry;
  logic              full;
  logic              empty;
  logic              a_acc;
  logic              b_acc;
  logic              push;
  logic              pop;
  logic [SW-1:0]     starve_cnt;
  logic [NREG-1:0]   busy_nxt;
  logic              err_hit;

  // Register-0 results are accepted but never enter the queue.
  assign a_ready    = !((starve_cnt == LIMIT) && !empty);
  assign b_ready    = !full;
  assign a_acc      = a_valid && a_ready;
  assign b_acc      = b_valid && b_ready;
  assign push       = b_acc && (b_rd != '0);
  assign pop        = !a_acc && !empty;
  assign push_entry = '{rd: b_rd, data: b_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  // Clear for the popped head is applied first so a same-cycle reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[head.rd] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
  end

  always_comb begin
    err_hit = 1'b0;
    if (a_acc && (a_rd != '0) && busy[a_rd])       err_hit = 1'b1;
    if (push && !busy[b_rd])                       err_hit = 1'b1;
    if (iss_valid && (iss_rd != '0) && busy[iss_rd]) err_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we         <= 1'b0;
      rw         <= '0;
      rwd        <= '0;
      busy       <= '0;
      waw_err    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      we <= 1'b0;
      if (a_acc) begin
        if (a_rd != '0) begin
          we  <= 1'b1;
          rw  <= a_rd;
          rwd <= a_data;
        end
      end else if (pop) begin
        we  <= 1'b1;
        rw  <= head.rd;
        rwd <= head.data;
      end

      if (empty || pop)  starve_cnt <= '0;
      else if (a_acc)    starve_cnt <= starve_cnt + 1'b1;

      busy <= busy_nxt;
      if (err_hit) waw_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (DEPTH=4, STARVE_LIMIT=3).
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        we;
  logic [4:0]  rw;
  logic [31:0] rwd;
  logic [31:0] busy;
  logic [2:0]  fifo_cnt;
  logic        waw_err;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .we        (we),
    .rw        (rw),
    .rwd       (rwd),
    .busy      (busy),
    .fifo_cnt  (fifo_cnt),
    .waw_err   (waw_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are settled afterwards.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_we", we, 0);
    chk("rst_rw", rw, 0);
    chk("rst_rwd", rwd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_err", waw_err, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);

    // ALU only
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11;
    #1 chk("alu_a_ready", a_ready, 1);
    cyc();
    a_valid = 1'b0;
    chk("alu_we", we, 1);
    chk("alu_rw", rw, 3);
    chk("alu_rwd", rwd, 32'h11);
    cyc();
    chk("alu_we_off", we, 0);

    // Long-latency path
    iss_valid = 1'b1; iss_rd = 5'd5;
    cyc();
    iss_valid = 1'b0;
    chk("b_busy_set", busy, 32'h20);
    cyc();
    b_valid = 1'b1; b_rd = 5'd5; b_data = 32'hAB;
    #1 chk("b_ready", b_ready, 1);
    cyc();
    b_valid = 1'b0;
    chk("b_cnt1", fifo_cnt, 1);
    chk("b_busy_hold", busy, 32'h20);
    chk("b_we_early", we, 0);
    cyc();
    chk("b_we", we, 1);
    chk("b_rw", rw, 5);
    chk("b_rwd", rwd, 32'hAB);
    chk("b_busy_clr", busy, 0);
    chk("b_cnt0", fifo_cnt, 0);
    chk("b_err", waw_err, 0);
    cyc();
    chk("b_we_off", we, 0);

    // Starvation
    iss_valid = 1'b1; iss_rd = 5'd9;
    cyc();
    iss_valid = 1'b0;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
    a_valid = 1'b1; a_rd = 5'd10; a_data = 32'hA0;
    cyc();
    b_valid = 1'b0;
    chk("st_first_rw", rw, 10);
    for (int i = 0; i < 3; i++) begin
      a_rd = 5'(11 + i); a_data = 32'(32'hA1 + i);
      #1 chk("st_a_ready_win", a_ready, 1);
      cyc();
      chk("st_a_rw", rw, 64'(11 + i));
    end
    a_rd = 5'd14; a_data = 32'hAE;
    #1 chk("st_a_ready_held", a_ready, 0);
    chk("st_cnt_pre", fifo_cnt, 1);
    cyc();
    chk("st_b_we", we, 1);
    chk("st_b_rw", rw, 9);
    chk("st_b_rwd", rwd, 32'h99);
    chk("st_busy", busy, 0);
    #1 chk("st_a_ready_back", a_ready, 1);
    cyc();
    a_valid = 1'b0;
    chk("st_a14_rw", rw, 14);
    chk("st_a14_rwd", rwd, 32'hAE);
    cyc();
    chk("st_we_off", we, 0);

    // FIFO full and order
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1'b1; iss_rd = 5'(20 + i);
      cyc();
    end
    iss_valid = 1'b0;
    chk("full_busy", busy, 32'h00F0_0000);
    a_valid = 1'b1; a_rd = 5'd1;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_rd = 5'(20 + i); b_data = 32'(32'hB0 + i);
      a_data = 32'(32'h100 + i);
      #1 chk("full_b_ready_pre", b_ready, 1);
      cyc();
      chk("full_a_we", we, 1);
      chk("full_a_rwd", rwd, 64'(32'h100 + i));
    end
    b_valid = 1'b0; a_data = 32'h104;
    #1 chk("full_cnt4", fifo_cnt, 4);
    chk("full_b_ready", b_ready, 0);
    chk("full_a_ready", a_ready, 0);
    cyc();
    a_valid = 1'b0;
    chk("full_pop0_rw", rw, 20);
    chk("full_pop0_rwd", rwd, 32'hB0);
    chk("full_cnt3", fifo_cnt, 3);
    chk("full_b_ready_back", b_ready, 1);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("full_pop_we", we, 1);
      chk("full_pop_rw", rw, 64'(20 + i));
      chk("full_pop_rwd", rwd, 64'(32'hB0 + i));
      chk("full_pop_cnt", fifo_cnt, 64'(3 - i));
    end
    chk("full_busy_clr", busy, 0);
    chk("full_err", waw_err, 0);

    // Register 0 and protocol errors
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h55;
    cyc();
    a_valid = 1'b0;
    chk("r0_a_we", we, 0);
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
    cyc();
    b_valid = 1'b0;
    chk("err_b_unbusy", waw_err, 1);
    cyc();
    chk("err_b_rw", rw, 7);
    cyc();
    chk("err_sticky", waw_err, 1);
    do_reset();
    chk("err_rst", waw_err, 0);
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h5;
    cyc();
    b_valid = 1'b0;
    chk("r0_b_cnt", fifo_cnt, 0);
    cyc();
    chk("r0_b_we", we, 0);
    chk("r0_b_err", waw_err, 0);
    iss_valid = 1'b1; iss_rd = 5'd8;
    cyc();
    iss_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd8; a_data = 32'h88;
    cyc();
    a_valid = 1'b0;
    chk("err_a_busy", waw_err, 1);
    chk("err_a_we", we, 1);
    chk("err_a_rw", rw, 8);
    chk("err_a_rwd", rwd, 32'h88);

    // Reset with queued entries
    a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1; b_rd = 5'(25 + i); b_data = 32'(32'hC0 + i);
      cyc();
    end
    b_valid = 1'b0;
    #1 chk("mr_cnt_pre", fifo_cnt, 3);
    chk("mr_busy_pre", busy, 32'h100);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    chk("mr_cnt", fifo_cnt, 0);
    chk("mr_busy", busy, 0);
    chk("mr_we", we, 0);
    chk("mr_err", waw_err, 0);
    chk("mr_b_ready", b_ready, 1);
    chk("mr_a_ready", a_ready, 1);
    cyc();
    chk("mr_we_after", we, 0);
    chk("mr_cnt_after", fifo_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
